fft_frame_seq: RTL

FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT frame sequencer and its neighbours:
//   fft_state_t  - sequencer state encoding (IDLE, LOAD, WAIT, DONE)
//   FFT_N        - default frame length in samples
//   FFT_TIMEOUT  - default result-beat watchdog limit in cycles
//   FFT_LOG2_N   - log2 of the default frame length
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fft_state_t;

  localparam int FFT_N       = 8;
  localparam int FFT_TIMEOUT = 64;
  localparam int FFT_LOG2_N  = $clog2(FFT_N);

endpackage

// File: rtl/fft_frame_seq.sv
// ---------------------------------------------------------------------------
// fft_frame_seq
// Frames a stream of signed samples into N-sample FFT input packets, then
// waits for N/2 result beats from the FFT pipeline before declaring the
// frame complete. The FFT core itself sits beside this block.
//
// Parameters:
//   N        frame length in samples (power of two, >= 4)
//   Q_IN     sample MSB index (samples are Q_IN+1 bits)
//   TIMEOUT  cycles allowed between result beats (watchdog build only)
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   s_valid/s_ready   sample handshake, s_data is the offered sample
//   fft_valid_in      sample strobe towards the FFT, one cycle after accept
//   fft_valid_packet  marks the last sample of the frame
//   fft_data_in       sample towards the FFT, bit-exact copy of s_data
//   fft_valid_out     one result beat (one output pair) from the FFT
//   busy              high whenever a frame is in progress
//   frame_done        one-cycle pulse when a frame completes
//   frame_count       completed frames, wraps modulo 256
//   error             sticky result-beat timeout flag
//
// Build option:
//   FFT_SEQ_TIMEOUT_EN  enables the WAIT watchdog; without it WAIT waits
//                       forever and error is tied low.
// ---------------------------------------------------------------------------
module fft_frame_seq
  import fft_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int Q_IN    = 15,
  parameter int TIMEOUT = FFT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [Q_IN:0] s_data,
  output logic               fft_valid_in,
  output logic               fft_valid_packet,
  output logic signed [Q_IN:0] fft_data_in,
  input  logic               fft_valid_out,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         frame_count,
  output logic               error
);

  // One extra bit over log2(N) so the counters can never overflow.
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(N - 1);
  localparam logic [CW-1:0] LAST_BEAT   = CW'(N / 2 - 1);

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd_count;
`else
  assign error = 1'b0;
`endif

  fft_state_t    state;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] beat_count;
  logic          accept;

  // A sample is taken whenever the source offers one while we are open.
  assign accept = s_valid && s_ready;

  // Sequencer: loads N samples, forwards each one a cycle later, waits for
  // N/2 result beats, pulses frame_done for one cycle and goes back to idle.
  // s_ready and busy are registered alongside the state so they always
  // describe the state the block is in during the current cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      sample_count     <= '0;
      beat_count       <= '0;
      s_ready          <= 1'b1;
      busy             <= 1'b0;
      fft_valid_in     <= 1'b0;
      fft_valid_packet <= 1'b0;
      fft_data_in      <= '0;
      frame_done       <= 1'b0;
      frame_count      <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
      wd_count         <= '0;
      error            <= 1'b0;
`endif
    end else begin
      fft_valid_in     <= accept;
      fft_valid_packet <= 1'b0;
      frame_done       <= 1'b0;
      if (accept) begin
        fft_data_in <= s_data;
      end

      case (state)
        IDLE: begin
          // The first accepted sample is index 0; the counter then
          // points at the index of the next sample expected.
          if (accept) begin
            state        <= LOAD;
            sample_count <= CW'(1);
            busy         <= 1'b1;
          end
        end

        LOAD: begin
          // Gaps in s_valid simply hold the counter.
          if (accept) begin
            if (sample_count == LAST_SAMPLE) begin
              fft_valid_packet <= 1'b1;
              state            <= WAIT;
              s_ready          <= 1'b0;
              beat_count       <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
              wd_count         <= '0;
`endif
            end else begin
              sample_count <= sample_count + 1'b1;
            end
          end
        end

        WAIT: begin
          // A beat always wins over a watchdog expiry in the same cycle.
          if (fft_valid_out) begin
`ifdef FFT_SEQ_TIMEOUT_EN
            wd_count <= '0;
`endif
            if (beat_count == LAST_BEAT) begin
              state       <= DONE;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else begin
              beat_count <= beat_count + 1'b1;
            end
          end
`ifdef FFT_SEQ_TIMEOUT_EN
          else if (wd_count == WD_LAST) begin
            error        <= 1'b1;
            state        <= IDLE;
            s_ready      <= 1'b1;
            busy         <= 1'b0;
            sample_count <= '0;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
`endif
        end

        DONE: begin
          state        <= IDLE;
          s_ready      <= 1'b1;
          busy         <= 1'b0;
          sample_count <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
